// File: rtl/pic_init_sequencer.sv
// Host-side 8259 driver: writes ICW1..ICW4 + OCW1 after a start pulse, then
// answers pic_int with a two-pulse INTA cycle and captures the vector byte.

module pic_init_sequencer #(
  parameter logic [7:0]  ICW1_VAL     = 8'h11,
  parameter logic [7:0]  ICW2_VAL     = 8'hF0,
  parameter logic [7:0]  ICW3_VAL     = 8'h07,
  parameter logic [7:0]  ICW4_VAL     = 8'h0F,
  parameter logic [7:0]  OCW1_VAL     = 8'h00,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       init_done,
  output logic       pic_cs_n,
  output logic       pic_a0,
  output logic       pic_wr_n,
  output logic       pic_rd_n,
  output logic       pic_inta_n,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  input  logic       pic_int,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ack
);

  typedef enum logic [3:0] {
    StIdle, StWSetup, StWLow, StWHold, StWGap,
    StReady, StILow1, StIGap, StILow2, StIEnd
  } state_e;

  localparam logic [15:0] PulseLast = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GapLast   = 16'(GAP_CYCLES - 1);
  localparam logic        Sngl      = ICW1_VAL[1];
  localparam logic        Ic4       = ICW1_VAL[0];

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  vector_q, vector_d;
  logic        vector_valid_q, vector_valid_d;

  logic [7:0]  wr_byte;
  logic        wr_a0;
  logic [2:0]  step_nxt;

  // Step index 0..4 = ICW1, ICW2, ICW3, ICW4, OCW1
  always_comb begin
    wr_a0   = 1'b1;
    wr_byte = OCW1_VAL;
    case (step_q)
      3'd0:    begin wr_a0 = 1'b0; wr_byte = ICW1_VAL; end
      3'd1:    wr_byte = ICW2_VAL;
      3'd2:    wr_byte = ICW3_VAL;
      3'd3:    wr_byte = ICW4_VAL;
      default: wr_byte = OCW1_VAL;
    endcase
    step_nxt = step_q + 3'd1;
    if (step_nxt == 3'd2 && Sngl) step_nxt = 3'd3;
    if (step_nxt == 3'd3 && !Ic4) step_nxt = 3'd4;
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    cnt_d          = cnt_q;
    init_done_d    = init_done_q;
    vector_d       = vector_q;
    vector_valid_d = vector_valid_q;
    busy           = 1'b1;
    pic_cs_n       = 1'b1;
    pic_wr_n       = 1'b1;
    pic_inta_n     = 1'b1;
    pic_a0         = 1'b0;
    data_out       = 8'h00;
    data_oe        = 1'b0;

    if (vector_ack) vector_valid_d = 1'b0;

    case (state_q)
      StIdle, StReady: begin
        busy = 1'b0;
        if (start) begin
          state_d        = StWSetup;
          step_d         = 3'd0;
          init_done_d    = 1'b0;
          vector_valid_d = 1'b0;
        end else if (state_q == StReady && pic_int && (!vector_valid_q || vector_ack)) begin
          state_d = StILow1;
          cnt_d   = '0;
        end
      end
      StWSetup, StWLow, StWHold: begin
        pic_cs_n = 1'b0;
        pic_a0   = wr_a0;
        data_out = wr_byte;
        data_oe  = 1'b1;
        if (state_q == StWSetup) begin
          state_d = StWLow;
          cnt_d   = '0;
        end else if (state_q == StWHold) begin
          state_d = StWGap;
          cnt_d   = '0;
        end else begin
          pic_wr_n = 1'b0;
          if (cnt_q == PulseLast) state_d = StWHold;
          else                    cnt_d   = cnt_q + 16'd1;
        end
      end
      StWGap: begin
        if (cnt_q != GapLast) begin
          cnt_d = cnt_q + 16'd1;
        end else if (step_q == 3'd4) begin
          state_d     = StReady;
          init_done_d = 1'b1;
        end else begin
          step_d  = step_nxt;
          state_d = StWSetup;
        end
      end
      StILow1, StILow2: begin
        pic_inta_n = 1'b0;
        if (cnt_q != PulseLast) begin
          cnt_d = cnt_q + 16'd1;
        end else if (state_q == StILow1) begin
          state_d = StIGap;
          cnt_d   = '0;
        end else begin
          // Capture overrides a same-cycle ack.
          state_d        = StIEnd;
          vector_d       = data_in;
          vector_valid_d = 1'b1;
        end
      end
      StIGap: begin
        if (cnt_q == GapLast) begin
          state_d = StILow2;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StIEnd:  state_d = StReady;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      step_q         <= 3'd0;
      cnt_q          <= '0;
      init_done_q    <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      cnt_q          <= cnt_d;
      init_done_q    <= init_done_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
    end
  end

  assign pic_rd_n     = 1'b1;
  assign init_done    = init_done_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;

endmodule
